// File: rtl/segment_fader_pkg.sv
// Shared constants and types for the segment fader stage that drives the 7-segment pads.
package segment_pkg;
    localparam int SEG_N = 7;
    localparam int LVL_W = 4;
    localparam logic [LVL_W-1:0] LVL_MAX = {LVL_W{1'b1}};

    typedef logic [LVL_W-1:0] level_t;
    typedef logic [SEG_N-1:0] seg_vec_t;
endpackage

// File: rtl/segment_fader_channel.sv
// One segment: brightness level with saturating ramp toward its on/off target, plus PWM compare.
module seg_fade_channel
    import segment_pkg::*;
#(
    parameter int LW   = LVL_W,
    parameter int STEP = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_ena,
    input  logic          i_frame_tick,
    input  logic          i_fade_en,
    input  logic          i_tgt_on,
    input  logic [LW-1:0] i_pwm_cnt,
    output logic          o_on,
    output logic          o_not_at_tgt
);
    localparam logic [LW-1:0] W_MAX    = {LW{1'b1}};
    localparam logic [LW-1:0] W_STEP_L = LW'(STEP);
    localparam logic [LW:0]   W_STEP_E = (LW+1)'(STEP);

    logic [LW-1:0] r_level;
    logic [LW-1:0] w_target;
    logic [LW-1:0] w_next;
    logic [LW:0]   w_sum;

    assign w_target = {LW{i_tgt_on}};
    // One extra bit so a rising step past MAX is seen and clamped instead of wrapping.
    assign w_sum    = {1'b0, r_level} + W_STEP_E;

    // Next level one STEP toward target, clamped at both ends.
    always_comb begin
        w_next = r_level;
        if (r_level < w_target) begin
            if (w_sum > {1'b0, W_MAX}) begin
                w_next = W_MAX;
            end else begin
                w_next = w_sum[LW-1:0];
            end
        end else if (r_level > w_target) begin
            if (r_level < W_STEP_L) begin
                w_next = {LW{1'b0}};
            end else begin
                w_next = r_level - W_STEP_L;
            end
        end else begin
            w_next = r_level;
        end
    end

    // Level register: snaps every cycle without fading, steps on frame ticks with fading.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_level <= {LW{1'b0}};
        end else if (i_ena) begin
            if (!i_fade_en) begin
                r_level <= w_target;
            end else if (i_frame_tick) begin
                r_level <= w_next;
            end else begin
                r_level <= r_level;
            end
        end else begin
            r_level <= r_level;
        end
    end

    assign o_on         = (r_level == W_MAX) | (i_pwm_cnt < r_level);
    assign o_not_at_tgt = (r_level != w_target);
endmodule

// File: rtl/segment_fader.sv
// Fades each segment of the animator pattern in and out and renders the level as PWM on the pads.
module segment_fader #(
    parameter int NSEG  = segment_pkg::SEG_N,
    parameter int LVL_W = segment_pkg::LVL_W,
    parameter int STEP  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic            pwm_tick,
    input  logic            frame_tick,
    input  logic            fade_en,
    input  logic [NSEG-1:0] seg_in,
    output logic [NSEG-1:0] seg_out,
    output logic            busy
);
    logic [NSEG-1:0]  r_seg_q;
    logic [LVL_W-1:0] r_pwm_cnt;
    logic [NSEG-1:0]  r_seg_out;
    logic [NSEG-1:0]  w_on;
    logic [NSEG-1:0]  w_not_at_tgt;

    // Input capture; keeps sampling even while disabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg_q <= {NSEG{1'b0}};
        end else begin
            r_seg_q <= seg_in;
        end
    end

    // Free-running PWM phase, wrapping MAX to 0 with no pause.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pwm_cnt <= {LVL_W{1'b0}};
        end else if (ena && pwm_tick) begin
            r_pwm_cnt <= r_pwm_cnt + {{(LVL_W-1){1'b0}}, 1'b1};
        end else begin
            r_pwm_cnt <= r_pwm_cnt;
        end
    end

    for (genvar g = 0; g < NSEG; g++) begin : g_ch
        seg_fade_channel #(
            .LW   (LVL_W),
            .STEP (STEP)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_ena        (ena),
            .i_frame_tick (frame_tick),
            .i_fade_en    (fade_en),
            .i_tgt_on     (r_seg_q[g]),
            .i_pwm_cnt    (r_pwm_cnt),
            .o_on         (w_on[g]),
            .o_not_at_tgt (w_not_at_tgt[g])
        );
    end

    // Registered pad drive, forced dark while disabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg_out <= {NSEG{1'b0}};
        end else if (ena) begin
            r_seg_out <= w_on;
        end else begin
            r_seg_out <= {NSEG{1'b0}};
        end
    end

    assign seg_out = r_seg_out;
    assign busy    = |w_not_at_tgt;
endmodule

// File: tb/tb_segment_fader.sv
// Scoreboard bench for segment_fader: STEP=1 and STEP=4 instances share stimulus against an integer model.
module tb_segment_fader;
    logic       clk;
    logic       rst_n, ena, pwm_tick, frame_tick, fade_en;
    logic [6:0] seg_in;
    logic [6:0] seg_out0, seg_out1;
    logic       busy0, busy1;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        string      tag;
        logic [6:0] out0;
        logic       b0;
        logic [6:0] out1;
        logic       b1;
    } exp_t;
    exp_t sb_q[$];

    int         m_lvl[2][7];
    int         m_stp[2];
    int         m_pwm;
    logic [6:0] m_segq;

    segment_fader #(.NSEG(7), .LVL_W(4), .STEP(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .pwm_tick(pwm_tick), .frame_tick(frame_tick),
        .fade_en(fade_en), .seg_in(seg_in), .seg_out(seg_out0), .busy(busy0));

    segment_fader #(.NSEG(7), .LVL_W(4), .STEP(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .pwm_tick(pwm_tick), .frame_tick(frame_tick),
        .fade_en(fade_en), .seg_in(seg_in), .seg_out(seg_out1), .busy(busy1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Drive one cycle, advance the model across the coming edge, queue what the DUTs must show.
    task automatic step(input logic rst, input logic en, input logic pt, input logic ft,
                        input logic fe, input logic [6:0] si, input string tag);
        exp_t       e;
        logic [6:0] nout[2];
        logic       nb[2];
        int         tgt;
        rst_n = rst; ena = en; pwm_tick = pt; frame_tick = ft; fade_en = fe; seg_in = si;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 7; i++)
                nout[d][i] = en && (m_lvl[d][i] == 15 || m_pwm < m_lvl[d][i]);
            for (int i = 0; i < 7; i++) begin
                tgt = m_segq[i] ? 15 : 0;
                if (!rst) m_lvl[d][i] = 0;
                else if (en) begin
                    if (!fe) m_lvl[d][i] = tgt;
                    else if (ft) begin
                        if (m_lvl[d][i] < tgt)
                            m_lvl[d][i] = (m_lvl[d][i] + m_stp[d] > 15) ? 15 : m_lvl[d][i] + m_stp[d];
                        else if (m_lvl[d][i] > tgt)
                            m_lvl[d][i] = (m_lvl[d][i] - m_stp[d] < 0) ? 0 : m_lvl[d][i] - m_stp[d];
                    end
                end
            end
            if (!rst) nout[d] = 7'h00;
        end
        if (!rst) m_pwm = 0;
        else if (en && pt) m_pwm = (m_pwm + 1) % 16;
        m_segq = rst ? si : 7'h00;
        for (int d = 0; d < 2; d++) begin
            nb[d] = 1'b0;
            for (int i = 0; i < 7; i++)
                if (m_lvl[d][i] != (m_segq[i] ? 15 : 0)) nb[d] = 1'b1;
        end
        e.tag = tag; e.out0 = nout[0]; e.b0 = nb[0]; e.out1 = nout[1]; e.b1 = nb[1];
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Compare queued expectations against the pads away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({e.tag, "_out0"},  32'(seg_out0), 32'(e.out0));
            chk({e.tag, "_busy0"}, 32'(busy0),    32'(e.b0));
            chk({e.tag, "_out1"},  32'(seg_out1), 32'(e.out1));
            chk({e.tag, "_busy1"}, 32'(busy1),    32'(e.b1));
        end
    end

    initial begin
        int cnt;
        m_stp[0] = 1; m_stp[1] = 4; m_pwm = 0; m_segq = 7'h00;
        for (int d = 0; d < 2; d++) for (int i = 0; i < 7; i++) m_lvl[d][i] = 0;
        rst_n = 1'b0; ena = 1'b0; pwm_tick = 1'b0; frame_tick = 1'b0; fade_en = 1'b1; seg_in = 7'h00;

        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'(i % 2), 1'((i + 1) % 2), 1'b1, 7'h7F, "rst");
        chk("rst_pwm", 32'(dut0.r_pwm_cnt), 32'd0);

        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 7'h01, "idle");

        cnt = 0;
        for (int k = 1; k <= 15; k++) begin
            step(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b1, 7'h01, "fade_up");
            step(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1, 7'h01, "fade_up");
            if (k == 4) begin
                for (int j = 0; j < 18; j++) begin
                    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 7'h01, "duty");
                    if (j >= 2) cnt += int'(seg_out0[0]);
                end
                chk("duty4", 32'(cnt), 32'd4);
            end
        end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 7'h01, "full");

        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00, "clr");
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 7'h01, "rise7");
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 7'h01, "rise7");
        end
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 7'h00, "reverse");
            step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 7'h00, "reverse");
        end

        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00, "snap");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'h7F, "snap");

        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 7'h2A, "both");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 7'h2A, "ena0");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 7'h2A, "resume");
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 7'h2A, "rst_mid");

        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 40) != 0), 1'($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 5) != 0),
                 ($urandom_range(0, 9) == 0) ? 7'($urandom) : seg_in, "rand");

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
